sprite_16x16: RTL and testbench

//  Draws one movable 16x16-pixel, single-colour sprite over a VGA scan. It sits

---
 rtl/sprite_16x16_pkg.sv | 34 +++
 rtl/sprite_16x16_rom.sv | 13 +
 rtl/sprite_16x16.sv | 90 +++++++++
 tb/tb_sprite_16x16.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sprite_16x16_pkg.sv
// Shared constants for the 16x16 sprite overlay: widths, cell geometry,
// colour constants, the default bitmap and the cell-clamping helper.
package sprite_16x16_pkg;

  localparam int RGB_W      = 3;
  localparam int CELL_SHIFT = 4;
  localparam int SPRITE_DIM = 16;

  localparam logic [4:0] MAX_X_CELL    = 5'd31;
  localparam logic [4:0] MAX_Y_DEFAULT = 5'd29;

  localparam logic [RGB_W-1:0] COLOR_BLACK = 3'b000;
  localparam logic [RGB_W-1:0] COLOR_GREEN = 3'b010;
  localparam logic [RGB_W-1:0] COLOR_WHITE = 3'b111;

  // One word per sprite row; bit n is column n, 1 = opaque.
  localparam logic [SPRITE_DIM-1:0] SPRITE_BITMAP [SPRITE_DIM] = '{
    16'h0000, 16'h7FFE, 16'h7FFE, 16'h7FFE,
    16'h7FFE, 16'h7FFE, 16'h7FFE, 16'h7FFE,
    16'h7FFE, 16'h7FFE, 16'h7FFE, 16'h7FFE,
    16'h7FFE, 16'h7FFE, 16'h7FFE, 16'h0000
  };

  // sum is a 7-bit two's-complement cell position; bit 6 set means negative.
  function automatic logic [4:0] clamp_cell(input logic [6:0] sum, input logic [4:0] hi);
    if (sum[6])
      return 5'd0;
    else if (sum[5:0] > {1'b0, hi})
      return hi;
    else
      return sum[4:0];
  endfunction

endpackage

// File: rtl/sprite_16x16_rom.sv
// Sprite bitmap lookup: relative row in, 16-bit row mask out (combinational).
module sprite_rom
  import sprite_16x16_pkg::*;
(
  input  logic [3:0]            row,
  output logic [SPRITE_DIM-1:0] row_word
);

  always_comb begin
    row_word = SPRITE_BITMAP[row];
  end

endmodule

// File: rtl/sprite_16x16.sv
// Single-colour 16x16 sprite overlaid on a VGA pixel stream; position kept on a
// 16-pixel cell grid, updated by absolute or saturating relative commands.
module sprite_16x16
  import sprite_16x16_pkg::*;
#(
  parameter logic [4:0]       RESET_X     = 5'd0,
  parameter logic [4:0]       RESET_Y     = 5'd0,
  parameter logic [RGB_W-1:0] RESET_COLOR = COLOR_GREEN,
  parameter logic [4:0]       MAX_Y       = MAX_Y_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [9:0]       iColumnCount,
  input  logic [9:0]       iRowCount,
  input  logic             iEnable,
  input  logic [RGB_W-1:0] iColorBack,
  input  logic             iChangePos,
  input  logic             iAbsolute,
  input  logic [4:0]       iSetX,
  input  logic [4:0]       iSetY,
  input  logic [RGB_W-1:0] iNewColor,
  input  logic             iSetColor,
  output logic [RGB_W-1:0] oRGB
);

  logic [4:0]       pos_x_reg, pos_x_next;
  logic [4:0]       pos_y_reg, pos_y_next;
  logic [RGB_W-1:0] color_reg, color_next;
  logic [RGB_W-1:0] rgb_reg, rgb_next;

  logic [6:0]            sum_x, sum_y;
  logic [10:0]           col_rel, row_rel;
  logic                  hit, opaque;
  logic [SPRITE_DIM-1:0] row_word;

  // Position/colour update
  always_comb begin
    pos_x_next = pos_x_reg;
    pos_y_next = pos_y_reg;
    color_next = color_reg;
    sum_x      = {2'b00, pos_x_reg} + {{2{iSetX[4]}}, iSetX};
    sum_y      = {2'b00, pos_y_reg} + {{2{iSetY[4]}}, iSetY};
    if (iChangePos) begin
      if (iAbsolute) begin
        pos_x_next = iSetX;
        pos_y_next = (iSetY > MAX_Y) ? MAX_Y : iSetY;
      end else begin
        pos_x_next = clamp_cell(sum_x, MAX_X_CELL);
        pos_y_next = clamp_cell(sum_y, MAX_Y);
      end
    end
    if (iSetColor)
      color_next = iNewColor;
  end

  // 11-bit differences: anything left of / above the origin goes negative and misses.
  assign col_rel = {1'b0, iColumnCount} - {2'b00, pos_x_reg, 4'b0000};
  assign row_rel = {1'b0, iRowCount}    - {2'b00, pos_y_reg, 4'b0000};
  assign hit     = (col_rel[10:CELL_SHIFT] == '0) && (row_rel[10:CELL_SHIFT] == '0);

  sprite_rom u_rom (
    .row      (row_rel[3:0]),
    .row_word (row_word)
  );

  assign opaque = row_word[col_rel[3:0]];

  always_comb begin
    rgb_next = iColorBack;
    if (iEnable && hit && opaque)
      rgb_next = color_reg;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pos_x_reg <= RESET_X;
      pos_y_reg <= RESET_Y;
      color_reg <= RESET_COLOR;
      rgb_reg   <= COLOR_BLACK;
    end else begin
      pos_x_reg <= pos_x_next;
      pos_y_reg <= pos_y_next;
      color_reg <= color_next;
      rgb_reg   <= rgb_next;
    end
  end

  assign oRGB = rgb_reg;

endmodule

// File: tb/tb_sprite_16x16.sv
// Self-checking bench for sprite_16x16: directed scenarios then random traffic,
// every cycle compared against an integer-arithmetic model of the sprite.
module tb_sprite_16x16;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] iColumnCount = '0;
  logic [9:0] iRowCount = '0;
  logic       iEnable = 1'b0;
  logic [2:0] iColorBack = '0;
  logic       iChangePos = 1'b0;
  logic       iAbsolute = 1'b0;
  logic [4:0] iSetX = '0;
  logic [4:0] iSetY = '0;
  logic [2:0] iNewColor = '0;
  logic       iSetColor = 1'b0;
  logic [2:0] oRGB;

  sprite_16x16 dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iColumnCount (iColumnCount),
    .iRowCount    (iRowCount),
    .iEnable      (iEnable),
    .iColorBack   (iColorBack),
    .iChangePos   (iChangePos),
    .iAbsolute    (iAbsolute),
    .iSetX        (iSetX),
    .iSetY        (iSetY),
    .iNewColor    (iNewColor),
    .iSetColor    (iSetColor),
    .oRGB         (oRGB)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cell position and colour as plain integers.
  int m_x = 0, m_y = 0, m_color = 2;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int to_signed5(input logic [4:0] v);
    return (v >= 16) ? int'(v) - 32 : int'(v);
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Pixel colour from the geometric rule: inside the 16x16 box and not on its edge.
  function automatic int model_pixel(input int col, input int row, input int en, input int back);
    int cr, rr;
    cr = col - 16 * m_x;
    rr = row - 16 * m_y;
    if (en != 0 && cr >= 1 && cr <= 14 && rr >= 1 && rr <= 14)
      return m_color;
    return back;
  endfunction

  task automatic cycle(input string tag, input bit rst, input int col, input int row,
                       input bit en, input int back, input bit chg, input bit absl,
                       input int sx, input int sy, input bit setc, input int newc);
    int exp;
    Reset        = rst;
    iColumnCount = 10'(col);
    iRowCount    = 10'(row);
    iEnable      = en;
    iColorBack   = 3'(back);
    iChangePos   = chg;
    iAbsolute    = absl;
    iSetX        = 5'(sx);
    iSetY        = 5'(sy);
    iSetColor    = setc;
    iNewColor    = 3'(newc);
    exp = rst ? 0 : model_pixel(col, row, int'(en), back);
    @(posedge Clock);
    #1;
    if (rst) begin
      m_x = 0; m_y = 0; m_color = 2;
    end else begin
      if (chg) begin
        if (absl) begin
          m_x = sx & 31;
          m_y = ((sy & 31) > 29) ? 29 : (sy & 31);
        end else begin
          m_x = clamp(m_x + to_signed5(5'(sx)), 0, 31);
          m_y = clamp(m_y + to_signed5(5'(sy)), 0, 29);
        end
      end
      if (setc) m_color = newc;
    end
    check(tag, int'(oRGB), exp);
    $display("cycle %s rst=%0d pix=(%0d,%0d) en=%0d chg=%0d abs=%0d d=(%0d,%0d) rgb=%0d exp=%0d",
             tag, rst, col, row, en, chg, absl, sx, sy, oRGB, exp);
  endtask

  initial begin
    int col, row;
    #2;
    // Reset and basic background pass-through
    cycle("reset",     1, 30, 30, 1, 7, 0, 0, 0, 0, 0, 0);
    cycle("reset_hold",1, 5, 5, 1, 7, 0, 0, 0, 0, 0, 0);
    cycle("outside",   0, 30, 30, 1, 7, 0, 0, 0, 0, 0, 0);
    cycle("rst_color", 0, 5, 5, 1, 7, 0, 0, 0, 0, 0, 0);
    // Colour load, then opaque interior and transparent border
    cycle("set_color", 0, 30, 30, 1, 7, 0, 0, 0, 0, 1, 1);
    cycle("opaque_5_5",0, 5, 5, 1, 7, 0, 0, 0, 0, 0, 0);
    cycle("border_0_0",0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
    cycle("border_15", 0, 15, 7, 1, 7, 0, 0, 0, 0, 0, 0);
    // Same-cycle pixel sees pre-update colour
    cycle("color_same",0, 5, 5, 1, 7, 0, 0, 0, 0, 1, 4);
    cycle("color_new", 0, 5, 5, 1, 7, 0, 0, 0, 0, 0, 0);
    // Relative +2,+3 held four cycles -> (8,12)
    for (int i = 0; i < 4; i++)
      cycle("rel_move", 0, 5, 5, 1, 7, 1, 0, 2, 3, 0, 0);
    cycle("rel_pix",   0, 130, 194, 1, 7, 0, 0, 0, 0, 0, 0);
    cycle("rel_edge",  0, 128, 194, 1, 7, 0, 0, 0, 0, 0, 0);
    // Absolute (2,3) twice
    cycle("abs_a",     0, 40, 56, 1, 7, 1, 1, 2, 3, 0, 0);
    cycle("abs_b",     0, 40, 56, 1, 7, 1, 1, 2, 3, 0, 0);
    cycle("abs_pix",   0, 40, 56, 1, 7, 0, 0, 0, 0, 0, 0);
    cycle("abs_back",  0, 30, 30, 1, 7, 0, 0, 0, 0, 0, 0);
    // Negative deltas saturating at zero
    for (int i = 0; i < 5; i++)
      cycle("sat_low", 0, 5, 5, 1, 6, 1, 0, 31, 30, 0, 0);
    cycle("sat_pix",   0, 5, 5, 1, 6, 0, 0, 0, 0, 0, 0);
    // Absolute Y above MAX_Y clamps to 29
    cycle("abs_y31",   0, 0, 0, 1, 6, 1, 1, 31, 31, 0, 0);
    cycle("y_clamp",   0, 500, 469, 1, 6, 0, 0, 0, 0, 0, 0);
    cycle("x31_edge",  0, 511, 469, 1, 6, 0, 0, 0, 0, 0, 0);
    // Positive deltas saturating at the far corner
    for (int i = 0; i < 3; i++)
      cycle("sat_high", 0, 500, 469, 1, 6, 1, 0, 15, 15, 0, 0);
    // Enable low over opaque pixel
    cycle("disable",   0, 500, 469, 0, 5, 0, 0, 0, 0, 0, 0);
    // Reset in the middle of a move
    cycle("move",      0, 500, 469, 1, 5, 1, 0, 31, 31, 0, 0);
    cycle("mid_reset", 1, 500, 469, 1, 5, 1, 0, 31, 31, 1, 3);
    cycle("post_reset",0, 7, 7, 1, 5, 0, 0, 0, 0, 0, 0);

    // Randomized traffic, pixels biased around the current sprite
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        col = $urandom_range(0, 1023);
        row = $urandom_range(0, 1023);
      end else begin
        col = m_x * 16 + $urandom_range(0, 19) - 2;
        row = m_y * 16 + $urandom_range(0, 19) - 2;
        if (col < 0) col = 0;
        if (row < 0) row = 0;
      end
      cycle("random", ($urandom_range(0, 199) == 0), col, row,
            ($urandom_range(0, 7) != 0), $urandom_range(0, 7),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
            $urandom_range(0, 31), $urandom_range(0, 31),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
